// File: rtl/riscv_selfcheck_monitor.sv
// rtl/riscv_selfcheck_monitor.sv - WB-snooping shadow regfile, halt/timeout detect, expected-value checker
// Runs until the core's pc sits still (halt) or a cycle budget expires, then scans the expected table.
module riscv_selfcheck_monitor #(
  parameter int  XLEN           = 32,
  parameter int  NUM_CHECKS     = 16,
  parameter int  TIMEOUT_CYCLES = 10000,
  parameter int  HALT_CYCLES    = 8,
  parameter int  CNT_W          = 32,
  localparam int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             exp_we_i,
  input  logic [IDX_W-1:0] exp_idx_i,
  input  logic [4:0]       exp_reg_i,
  input  logic [XLEN-1:0]  exp_val_i,
  input  logic             wb_reg_write_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic [XLEN-1:0]  wb_write_data_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [IDX_W:0]   fail_count_o,
  output logic [IDX_W-1:0] first_fail_idx_o,
  output logic [XLEN-1:0]  first_fail_actual_o,
  output logic [CNT_W-1:0] cycle_count_o
);
  localparam int ST_W = $clog2(HALT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   shadow_q [32];
  logic [XLEN-1:0]   shadow_d [32];
  logic [4:0]        tbl_reg_q [NUM_CHECKS];
  logic [4:0]        tbl_reg_d [NUM_CHECKS];
  logic [XLEN-1:0]   tbl_val_q [NUM_CHECKS];
  logic [XLEN-1:0]   tbl_val_d [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] tbl_en_q, tbl_en_d;
  logic [XLEN-1:0]   pc_prev_q, pc_prev_d;
  logic [ST_W-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    fail_q, fail_d;
  logic [IDX_W-1:0]  ffi_q, ffi_d;
  logic [XLEN-1:0]   ffa_q, ffa_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   chk_actual;
  logic              chk_mismatch;

  assign chk_actual   = shadow_q[tbl_reg_q[idx_q]];
  assign chk_mismatch = tbl_en_q[idx_q] && (chk_actual != tbl_val_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    tbl_reg_d = tbl_reg_q;
    tbl_val_d = tbl_val_q;
    tbl_en_d  = tbl_en_q;
    pc_prev_d = pc_prev_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    ffi_d     = ffi_q;
    ffa_d     = ffa_q;
    timeout_d = timeout_q;

    if ((state_q == S_IDLE || state_q == S_DONE) && exp_we_i) begin
      tbl_reg_d[exp_idx_i] = exp_reg_i;
      tbl_val_d[exp_idx_i] = exp_val_i;
      tbl_en_d[exp_idx_i]  = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          for (int i = 0; i < 32; i++) shadow_d[i] = '0;
          pc_prev_d = pc_i;
          stable_d  = '0;
          cnt_d     = '0;
          fail_d    = '0;
          ffi_d     = '0;
          ffa_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (wb_reg_write_i && wb_rd_addr_i != 5'd0) shadow_d[wb_rd_addr_i] = wb_write_data_i;
        stable_d  = (pc_i == pc_prev_q) ? stable_q + ST_W'(1) : '0;
        pc_prev_d = pc_i;
        // halt takes priority so a coinciding timeout is not reported
        if (stable_d == ST_W'(HALT_CYCLES - 1)) begin
          state_d = S_CHECK;
          idx_d   = '0;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = S_CHECK;
          idx_d     = '0;
          timeout_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (chk_mismatch) begin
          fail_d = fail_q + (IDX_W+1)'(1);
          if (fail_q == '0) begin
            ffi_d = idx_q;
            ffa_d = chk_actual;
          end
        end
        if (idx_q == IDX_W'(NUM_CHECKS - 1)) state_d = S_DONE;
        else                                 idx_d   = idx_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_reg_q[i] <= '0;
        tbl_val_q[i] <= '0;
      end
      tbl_en_q  <= '0;
      pc_prev_q <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      fail_q    <= '0;
      ffi_q     <= '0;
      ffa_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      tbl_reg_q <= tbl_reg_d;
      tbl_val_q <= tbl_val_d;
      tbl_en_q  <= tbl_en_d;
      pc_prev_q <= pc_prev_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      fail_q    <= fail_d;
      ffi_q     <= ffi_d;
      ffa_q     <= ffa_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o              = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done_o              = (state_q == S_DONE);
  assign pass_o              = done_o && (fail_q == '0) && !timeout_q;
  assign timeout_o           = timeout_q;
  assign fail_count_o        = fail_q;
  assign first_fail_idx_o    = ffi_q;
  assign first_fail_actual_o = ffa_q;
  assign cycle_count_o       = cnt_q;

endmodule

// File: tb/tb_riscv_selfcheck_monitor.sv
// tb/tb_riscv_selfcheck_monitor.sv - scoreboard bench for riscv_selfcheck_monitor
// Runs are described as per-cycle traces; a trace-level model predicts the end result.
module tb_riscv_selfcheck_monitor;
  localparam int NC = 16;
  localparam int TO = 100;
  localparam int HC = 8;
  localparam logic [31:0] HOLD_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_idx = '0;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_val = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] pc = '0;
  logic        busy, done, pass, timeout;
  logic [4:0]  fail_count;
  logic [3:0]  ff_idx;
  logic [31:0] ff_act, cyc;

  always #5 clk = ~clk;

  riscv_selfcheck_monitor #(
    .XLEN(32), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .HALT_CYCLES(HC), .CNT_W(32)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .exp_we_i(exp_we),
    .exp_idx_i(exp_idx), .exp_reg_i(exp_reg), .exp_val_i(exp_val),
    .wb_reg_write_i(wb_we), .wb_rd_addr_i(wb_rd), .wb_write_data_i(wb_data), .pc_i(pc),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .fail_count_o(fail_count), .first_fail_idx_o(ff_idx),
    .first_fail_actual_o(ff_act), .cycle_count_o(cyc)
  );

  typedef struct {
    bit          pass;
    bit          to;
    int          fails;
    int          ffi;
    logic [31:0] ffa;
    int          cyc;
    int          blen;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  m_reg [NC];
  logic [31:0] m_val [NC];
  bit          m_en  [NC];
  logic [31:0] tr_pc0;
  logic [31:0] tr_pc[$];
  bit          tr_we[$];
  logic [4:0]  tr_rd[$];
  logic [31:0] tr_data[$];
  logic [4:0]  plan_rd[$];
  logic [31:0] plan_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pc_at(input int s, input int hold_at, input int rep);
    return (s >= hold_at) ? HOLD_PC : 32'h1000 + 32'(4 * (s / rep));
  endfunction

  task automatic plan(input logic [4:0] rd, input logic [31:0] d);
    plan_rd.push_back(rd);
    plan_data.push_back(d);
  endtask

  task automatic load(input logic [3:0] idx, input logic [4:0] r, input logic [31:0] v);
    @(negedge clk);
    exp_we = 1'b1; exp_idx = idx; exp_reg = r; exp_val = v;
    @(negedge clk);
    exp_we = 1'b0;
    m_reg[idx] = r; m_val[idx] = v; m_en[idx] = 1'b1;
  endtask

  // Build the trace and predict the outcome: shadow is the last write per register,
  // the run ends when HC equal pc samples are seen in a row, or after TO cycles.
  task automatic build_run(input int hold_at, input int rep, input bit rand_wb);
    logic [31:0] sh [32];
    logic [31:0] prev, p, d;
    logic [4:0]  rd;
    bit          we, fin, to;
    int          run, k;
    exp_t        e;
    tr_pc.delete(); tr_we.delete(); tr_rd.delete(); tr_data.delete();
    foreach (sh[i]) sh[i] = '0;
    tr_pc0 = pc_at(0, hold_at, rep);
    prev = tr_pc0; run = 1; k = 0; fin = 1'b0; to = 1'b0;
    while (!fin) begin
      k++;
      p = pc_at(k, hold_at, rep);
      if (plan_rd.size() > 0) begin
        we = 1'b1; rd = plan_rd.pop_front(); d = plan_data.pop_front();
      end else if (rand_wb && $urandom_range(0, 1) == 1) begin
        we = 1'b1; rd = 5'($urandom_range(0, 31)); d = 32'($urandom_range(0, 3));
      end else begin
        we = 1'b0; rd = '0; d = '0;
      end
      tr_pc.push_back(p); tr_we.push_back(we); tr_rd.push_back(rd); tr_data.push_back(d);
      if (we && rd != 5'd0) sh[rd] = d;
      run = (p == prev) ? run + 1 : 1;
      prev = p;
      if (run == HC) fin = 1'b1;
      else if (k == TO) begin fin = 1'b1; to = 1'b1; end
    end
    e.fails = 0; e.ffi = 0; e.ffa = '0;
    for (int i = 0; i < NC; i++) begin
      if (m_en[i] && sh[m_reg[i]] != m_val[i]) begin
        if (e.fails == 0) begin e.ffi = i; e.ffa = sh[m_reg[i]]; end
        e.fails++;
      end
    end
    e.to = to; e.pass = (e.fails == 0) && !to; e.cyc = k; e.blen = k + NC;
    exp_q.push_back(e);
  endtask

  task automatic drive_run(input bit poke);
    @(negedge clk);
    start = 1'b1; pc = tr_pc0; wb_we = 1'b1; wb_rd = 5'd9; wb_data = $urandom | 32'h1;
    for (int i = 0; i < tr_pc.size(); i++) begin
      @(negedge clk);
      pc = tr_pc[i]; wb_we = tr_we[i]; wb_rd = tr_rd[i]; wb_data = tr_data[i];
      if (poke && i == 1) begin
        start = 1'b1; exp_we = 1'b1;
        exp_idx = 4'($urandom_range(0, NC - 1));
        exp_reg = 5'($urandom_range(1, 31));
        exp_val = $urandom | 32'h100;
      end else begin
        start = 1'b0; exp_we = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0; exp_we = 1'b0; wb_we = 1'b0; pc = 32'h0000_F000;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_wait_done actual=not_done required=done", name);
    end
  endtask

  initial begin : monitor
    int   blen;
    bit   done_prev;
    exp_t e;
    blen = 0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      chk("busy_done_exclusive", 64'(busy & done), 64'd0);
      chk("pass_outside_done", 64'(pass & ~done), 64'd0);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=done required=no_pending_run");
        end else begin
          e = exp_q.pop_front();
          chk("sb_pass", 64'(pass), 64'(e.pass));
          chk("sb_timeout", 64'(timeout), 64'(e.to));
          chk("sb_fail_count", 64'(fail_count), 64'(e.fails));
          chk("sb_first_fail_idx", 64'(ff_idx), 64'(e.ffi));
          chk("sb_first_fail_actual", 64'(ff_act), 64'(e.ffa));
          chk("sb_cycle_count", 64'(cyc), 64'(e.cyc));
          chk("sb_busy_cycles", 64'(blen), 64'(e.blen));
        end
      end
      blen = busy ? blen + 1 : 0;
      done_prev = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    for (int i = 0; i < NC; i++) begin m_en[i] = 1'b0; m_reg[i] = '0; m_val[i] = '0; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_fail_count", 64'(fail_count), 64'd0);
    chk("rst_first_fail_idx", 64'(ff_idx), 64'd0);
    chk("rst_first_fail_actual", 64'(ff_act), 64'd0);
    chk("rst_cycle_count", 64'(cyc), 64'd0);

    load(4'd0, 5'd5, 32'd1); load(4'd1, 5'd6, 32'd2); load(4'd2, 5'd7, 32'd4);
    plan(5'd5, 32'd1); plan(5'd6, 32'd2); plan(5'd7, 32'd4);
    build_run(4, 1, 1'b0); drive_run(1'b0); wait_done("t1");
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_fail_count", 64'(fail_count), 64'd0);

    load(4'd3, 5'd18, 32'hAA);
    plan(5'd5, 32'd1); plan(5'd6, 32'd2); plan(5'd7, 32'd4); plan(5'd18, 32'hAB);
    build_run(5, 1, 1'b0); drive_run(1'b0); wait_done("t2");
    chk("t2_pass", 64'(pass), 64'd0);
    chk("t2_fail_count", 64'(fail_count), 64'd1);
    chk("t2_first_fail_idx", 64'(ff_idx), 64'd3);
    chk("t2_first_fail_actual", 64'(ff_act), 64'hAB);

    plan(5'd5, 32'd1); plan(5'd6, 32'd2); plan(5'd7, 32'd4); plan(5'd18, 32'hAB);
    build_run(1000, 1, 1'b0); drive_run(1'b0); wait_done("t3");
    chk("t3_timeout", 64'(timeout), 64'd1);
    chk("t3_cycle_count", 64'(cyc), 64'd100);
    chk("t3_pass", 64'(pass), 64'd0);

    load(4'd4, 5'd0, 32'd0); load(4'd5, 5'd9, 32'd0);
    plan(5'd0, 32'hFFFF_FFFF); plan(5'd5, 32'd1); plan(5'd6, 32'd2); plan(5'd7, 32'd4);
    plan(5'd18, 32'hAA);
    build_run(6, 1, 1'b0); drive_run(1'b0); wait_done("t4");
    chk("t4_pass", 64'(pass), 64'd1);

    build_run(10, 1, 1'b1); drive_run(1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    for (int i = 0; i < NC; i++) m_en[i] = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_fail_count", 64'(fail_count), 64'd0);
    chk("t5_cycle_count", 64'(cyc), 64'd0);
    build_run(10, 2, 1'b1); drive_run(1'b0); wait_done("t5");
    chk("t5_pass", 64'(pass), 64'd1);

    load(4'd0, 5'd5, 32'd1); load(4'd1, 5'd6, 32'd2); load(4'd2, 5'd7, 32'd4);
    plan(5'd5, 32'd1); plan(5'd6, 32'd2); plan(5'd7, 32'd4);
    build_run(TO - HC + 1, 1, 1'b0); drive_run(1'b0); wait_done("t6");
    chk("t6_timeout", 64'(timeout), 64'd0);
    chk("t6_cycle_count", 64'(cyc), 64'(TO));
    chk("t6_pass", 64'(pass), 64'd1);

    load(4'd0, 5'd5, 32'h55);
    plan(5'd5, 32'd1); plan(5'd6, 32'd2); plan(5'd7, 32'd4);
    build_run(5, 1, 1'b0); drive_run(1'b1); wait_done("t7");
    chk("t7_fail_count", 64'(fail_count), 64'd1);
    chk("t7_first_fail_idx", 64'(ff_idx), 64'd0);
    chk("t7_first_fail_actual", 64'(ff_act), 64'd1);

    for (int it = 0; it < 20; it++) begin
      nl = $urandom_range(0, 3);
      for (int j = 0; j < nl; j++)
        load(4'($urandom_range(0, NC - 1)), 5'($urandom_range(0, 31)), 32'($urandom_range(0, 3)));
      build_run($urandom_range(0, 110), $urandom_range(1, 5), 1'b1);
      drive_run(1'($urandom_range(0, 1)));
      wait_done("rand");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
